// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C-to-memory bridge.
package i2c_slave_pkg;

    localparam int   BYTE_W = 8;
    localparam logic ACK    = 1'b0;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEV_ADDR = 4'd1,
        RW       = 4'd2,
        ACK_DEV  = 4'd3,
        MEM_ADDR = 4'd4,
        ACK_ADDR = 4'd5,
        TX_DATA  = 4'd6,
        RX_DATA  = 4'd7,
        ACK_WR   = 4'd8,
        ACK_RD   = 4'd9,
        WAIT     = 4'd10
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk8x domain and turns them into edge and
// START/STOP strobes, each one clk8x cycle wide.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_s;

    // Reset to the idle-bus level so no phantom edge appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_ff   <= 2'b11;
            sda_ff   <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[0], scl};
            sda_ff   <= {sda_ff[0], sda};
            scl_prev <= scl_ff[1];
            sda_prev <= sda_ff[1];
        end
    end

    assign scl_s     = scl_ff[1];
    assign sda_s     = sda_ff[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: matches a device ID, takes a memory address, then reads or
// writes one byte of a synchronous byte-wide memory per transaction.
module i2c_slave
    import i2c_slave_pkg::*;
(
    input  logic              clk8x,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    input  logic [BYTE_W-1:0] id,
    output logic              mem_clk,
    output logic              mem_ce,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [BYTE_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [3:0]        state,
    output logic [BYTE_W-1:0] s_a_b_m
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic              sda_low_q, sda_low_d;
    logic              rw_q, rw_d;
    logic              ce_q, ce_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              rd_wait_q;

    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic [BYTE_W-1:0] byte_in;

    i2c_bus_sync u_sync (
        .clk       (clk8x),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in = {shift_q[BYTE_W-2:0], sda_s};

    always_ff @(posedge clk8x) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sda_low_q <= 1'b0;
            rw_q      <= 1'b0;
            ce_q      <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            rd_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sda_low_q <= sda_low_d;
            rw_q      <= rw_d;
            ce_q      <= ce_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            rd_wait_q <= rden_q;
        end
    end

    // SDA only changes on SCL fall; protocol decisions are made on SCL rise.
    // ACK slots are driven from the fall entering them until the next fall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sda_low_d = sda_low_q;
        rw_d      = rw_q;
        ce_d      = 1'b0;
        rden_d    = 1'b0;
        wren_d    = 1'b0;

        if (rd_wait_q) begin
            shift_d = mem_rdata;
        end

        if (start_det) begin
            state_d   = DEV_ADDR;
            cnt_d     = 4'd0;
            sda_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            sda_low_d = 1'b0;
        end else if (scl_fall) begin
            case (state_q)
                ACK_DEV, ACK_ADDR, ACK_WR: sda_low_d = 1'b1;
                TX_DATA: begin
                    if (cnt_q == 4'd8) begin
                        sda_low_d = 1'b0;
                        state_d   = ACK_RD;
                    end else begin
                        sda_low_d = ~shift_q[BYTE_W-1];
                        shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
                        cnt_d     = cnt_q + 4'd1;
                    end
                end
                default: sda_low_d = 1'b0;
            endcase
        end else if (scl_rise) begin
            case (state_q)
                DEV_ADDR: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        state_d = (byte_in == id) ? RW : WAIT;
                    end
                end
                RW: begin
                    rw_d    = sda_s;
                    state_d = ACK_DEV;
                end
                ACK_DEV: begin
                    cnt_d   = 4'd0;
                    state_d = MEM_ADDR;
                end
                MEM_ADDR: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        addr_d  = byte_in;
                        state_d = ACK_ADDR;
                    end
                end
                ACK_ADDR: begin
                    cnt_d = 4'd0;
                    if (rw_q) begin
                        ce_d    = 1'b1;
                        rden_d  = 1'b1;
                        state_d = TX_DATA;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        wdata_d = byte_in;
                        ce_d    = 1'b1;
                        wren_d  = 1'b1;
                        state_d = ACK_WR;
                    end
                end
                ACK_WR, ACK_RD: state_d = WAIT;
                default: ;
            endcase
        end
    end

    assign sda       = sda_low_q ? ACK : 1'bz;
    assign mem_clk   = clk8x;
    assign mem_ce    = ce_q;
    assign mem_rden  = rden_q;
    assign mem_wren  = wren_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign state     = state_q;
    assign s_a_b_m   = shift_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench: bit-banged I2C master plus a byte memory, checked against a
// transaction-level model of what the target should answer.
module tb_i2c_slave;

    localparam int         QTR    = 4;
    localparam logic [7:0] DUT_ID = 8'h01;

    logic       clk8x = 1'b0;
    logic       reset = 1'b1;
    logic       scl_pin = 1'b1;
    logic       master_low = 1'b0;
    wire        sda;
    logic [7:0] dut_id = DUT_ID;
    wire        mem_clk;
    wire        mem_ce;
    wire        mem_rden;
    wire        mem_wren;
    wire  [7:0] mem_addr;
    wire  [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    wire  [3:0] state;
    wire  [7:0] s_a_b_m;

    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];
    logic       preload_en = 1'b0;
    logic [7:0] preload_addr = 8'h00;
    logic [7:0] preload_data = 8'h00;

    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int strobe_err = 0;
    logic [7:0] last_rd_addr = 8'h00;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic rden_prev = 1'b0;
    logic wren_prev = 1'b0;
    bit   bus_idle = 1'b1;

    assign sda = master_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk8x = ~clk8x;

    i2c_slave dut (
        .clk8x     (clk8x),
        .reset     (reset),
        .scl       (scl_pin),
        .sda       (sda),
        .id        (dut_id),
        .mem_clk   (mem_clk),
        .mem_ce    (mem_ce),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state     (state),
        .s_a_b_m   (s_a_b_m)
    );

    // Synchronous memory device: read data appears one cycle after ce&rden.
    always @(posedge mem_clk) begin
        if (preload_en)
            dev_mem[preload_addr] <= preload_data;
        else if (mem_ce && mem_wren)
            dev_mem[mem_addr] <= mem_wdata;
        if (mem_ce && mem_rden)
            mem_rdata <= dev_mem[mem_addr];
    end

    // Strobe monitor: counts pulses and flags any wider than one cycle or without ce.
    always @(negedge clk8x) begin
        if (mem_rden) begin
            rd_pulses++;
            last_rd_addr = mem_addr;
            if (!mem_ce || rden_prev) strobe_err++;
        end
        if (mem_wren) begin
            wr_pulses++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            if (!mem_ce || wren_prev) strobe_err++;
        end
        rden_prev = mem_rden;
        wren_prev = mem_wren;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk8x);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        preload_addr = a;
        preload_data = d;
        preload_en   = 1'b1;
        wait_cycles(1);
        preload_en   = 1'b0;
        ref_mem[a]   = d;
    endtask

    task automatic clock_bit(input logic drive_bit, output logic seen);
        master_low = ~drive_bit;
        wait_cycles(QTR);
        scl_pin = 1'b1;
        wait_cycles(QTR);
        seen = sda;
        wait_cycles(QTR);
        scl_pin = 1'b0;
        wait_cycles(QTR);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(b[i], s);
            seen[i] = s;
        end
    endtask

    task automatic bus_start();
        if (!bus_idle) begin
            master_low = 1'b0;
            wait_cycles(QTR);
            scl_pin = 1'b1;
            wait_cycles(QTR);
        end
        master_low = 1'b1;
        wait_cycles(QTR);
        scl_pin = 1'b0;
        wait_cycles(QTR);
        bus_idle = 1'b0;
    endtask

    task automatic bus_stop();
        master_low = 1'b1;
        wait_cycles(QTR);
        scl_pin = 1'b1;
        wait_cycles(QTR);
        master_low = 1'b0;
        wait_cycles(QTR);
        bus_idle = 1'b1;
    endtask

    // One complete frame; the expected answer comes from the ID rule and ref_mem.
    task automatic applyStimulus(input logic [7:0] dev, input logic rw, input logic [7:0] addr,
                                 input logic [7:0] data, input logic mack, input bit do_stop);
        logic [7:0] seen;
        logic       s;
        bit         match;
        int         rd0;
        int         wr0;
        match = (dev == DUT_ID);
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        bus_start();
        checkOutput("start_state", 32'(state), 32'd1);
        send_byte(dev, seen);
        clock_bit(rw, s);
        clock_bit(1'b1, s);
        checkOutput("dev_ack", 32'(s), match ? 32'd0 : 32'd1);
        send_byte(addr, seen);
        clock_bit(1'b1, s);
        checkOutput("addr_ack", 32'(s), match ? 32'd0 : 32'd1);
        if (rw) begin
            send_byte(8'hFF, seen);
            checkOutput("rd_data", 32'(seen), match ? 32'(ref_mem[addr]) : 32'hFF);
            clock_bit(mack, s);
        end else begin
            send_byte(data, seen);
            clock_bit(1'b1, s);
            checkOutput("wr_ack", 32'(s), match ? 32'd0 : 32'd1);
            if (match) ref_mem[addr] = data;
        end
        checkOutput("end_state", 32'(state), 32'd10);
        checkOutput("rd_pulses", 32'(rd_pulses - rd0), (match && rw) ? 32'd1 : 32'd0);
        checkOutput("wr_pulses", 32'(wr_pulses - wr0), (match && !rw) ? 32'd1 : 32'd0);
        if (match && rw)
            checkOutput("rd_addr", 32'(last_rd_addr), 32'(addr));
        if (match && !rw) begin
            checkOutput("wr_addr", 32'(last_wr_addr), 32'(addr));
            checkOutput("wr_data", 32'(last_wr_data), 32'(data));
        end
        if (do_stop) begin
            bus_stop();
            checkOutput("idle_state", 32'(state), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seen;
        logic       s;
        logic [7:0] dev;
        int         rd0;
        int         wr0;

        $display("[TB] reset");
        reset = 1'b1;
        wait_cycles(2);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_sda", 32'(sda), 32'd1);
        checkOutput("rst_ce", 32'(mem_ce), 32'd0);
        checkOutput("rst_rden", 32'(mem_rden), 32'd0);
        checkOutput("rst_wren", 32'(mem_wren), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_shift", 32'(s_a_b_m), 32'd0);
        reset = 1'b0;
        wait_cycles(4);

        for (int a = 0; a < 17; a++)
            preload(8'(a), 8'($urandom_range(0, 255)));
        preload(8'h01, 8'h05);
        preload(8'h10, 8'h00);

        $display("[TB] directed read / write / wrong id");
        applyStimulus(8'h01, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 8'h02, 8'h7F, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 8'h02, 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h02, 1'b0, 8'h03, 8'h55, 1'b0, 1'b1);
        applyStimulus(8'h80, 1'b1, 8'h03, 8'h00, 1'b1, 1'b1);

        $display("[TB] repeated START inside MEM_ADDR");
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        bus_start();
        send_byte(DUT_ID, seen);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        checkOutput("abort_dev_ack", 32'(s), 32'd0);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        bus_start();
        checkOutput("abort_state", 32'(state), 32'd1);
        bus_stop();
        checkOutput("abort_idle", 32'(state), 32'd0);
        checkOutput("abort_rd", 32'(rd_pulses - rd0), 32'd0);
        checkOutput("abort_wr", 32'(wr_pulses - wr0), 32'd0);

        $display("[TB] reset during TX_DATA");
        bus_start();
        send_byte(DUT_ID, seen);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        send_byte(8'h10, seen);
        clock_bit(1'b1, s);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        checkOutput("tx_bit", 32'(s), 32'd0);
        checkOutput("tx_drive", 32'(sda), 32'd0);
        reset = 1'b1;
        wait_cycles(1);
        checkOutput("tx_rst_sda", 32'(sda), 32'd1);
        checkOutput("tx_rst_state", 32'(state), 32'd0);
        wait_cycles(1);
        reset = 1'b0;
        master_low = 1'b0;
        scl_pin = 1'b1;
        wait_cycles(2 * QTR);
        bus_idle = 1'b1;
        checkOutput("tx_rst_idle", 32'(state), 32'd0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                dev = DUT_ID;
            end else begin
                dev = 8'($urandom_range(0, 255));
                if (dev == DUT_ID) dev = 8'h42;
            end
            applyStimulus(dev, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end
        if (!bus_idle) begin
            bus_stop();
            checkOutput("final_idle", 32'(state), 32'd0);
        end

        checkOutput("strobe_shape", 32'(strobe_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
